line_clear_engine: RTL and testbench

LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

---
 rtl/line_clear_engine.sv | 126 ++++++++++++
 tb/tb_line_clear_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/line_clear_engine.sv
// Line-clear engine: on each lock event it scans the board from bottom to top, removes full rows and accumulates a saturating line count.
// Optional row flash before removal is enabled by defining LINE_CLEAR_FLASH_EN.
module line_clear_engine #(
    parameter int ROWS         = 20,
    parameter int COLS         = 10,
    parameter int TOTAL_WIDTH  = 16,
    parameter int FLASH_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ROWS-1:0][COLS-1:0]   board_in,
    output logic [ROWS-1:0][COLS-1:0]   board_out,
    output logic                        clearing_line,
    output logic                        done,
    output logic [2:0]                  lines_cleared,
    output logic [TOTAL_WIDTH-1:0]      total_lines,
    output logic [ROWS-1:0]             flash_mask
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

`ifdef LINE_CLEAR_FLASH_EN
    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, SCAN, FLASH, SHIFT, DONE} state_t;
    logic [FW-1:0] flash_cnt;
`else
    typedef enum logic [2:0] {IDLE, SCAN, SHIFT, DONE} state_t;
`endif

    state_t                      state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]   board_q;
    logic [RW-1:0]               row_idx;
    logic [2:0]                  pass_count;
    logic [2:0]                  lines_q;
    logic [TOTAL_WIDTH-1:0]      total_q;
    logic [TOTAL_WIDTH:0]        total_sum;
    logic [TOTAL_WIDTH-1:0]      total_next;
    logic                        row_full;

    assign row_full   = &board_q[row_idx];
    assign total_sum  = {1'b0, total_q} + (TOTAL_WIDTH+1)'(pass_count);
    assign total_next = total_sum[TOTAL_WIDTH] ? '1 : total_sum[TOTAL_WIDTH-1:0];

    always_comb begin
        state_d       = state_q;
        clearing_line = (state_q != IDLE);
        done          = (state_q == DONE);
        flash_mask    = '0;
        case (state_q)
            IDLE: if (start) state_d = SCAN;
            SCAN: begin
                if (row_full) begin
`ifdef LINE_CLEAR_FLASH_EN
                    state_d = FLASH;
`else
                    state_d = SHIFT;
`endif
                end else if (row_idx == '0) begin
                    state_d = DONE;
                end
            end
`ifdef LINE_CLEAR_FLASH_EN
            FLASH: begin
                flash_mask[row_idx] = 1'b1;
                if (flash_cnt == FW'(FLASH_CYCLES-1)) state_d = SHIFT;
            end
`endif
            SHIFT:   state_d = SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            board_q    <= '0;
            row_idx    <= RW'(ROWS-1);
            pass_count <= '0;
            lines_q    <= '0;
            total_q    <= '0;
`ifdef LINE_CLEAR_FLASH_EN
            flash_cnt  <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        board_q    <= board_in;
                        row_idx    <= RW'(ROWS-1);
                        pass_count <= '0;
                    end
                end
                SCAN: begin
                    // row_idx stays put on a full row so the row dropped into it is rescanned
                    if (!row_full && row_idx != '0) row_idx <= row_idx - 1'b1;
`ifdef LINE_CLEAR_FLASH_EN
                    flash_cnt <= '0;
`endif
                end
`ifdef LINE_CLEAR_FLASH_EN
                FLASH: flash_cnt <= flash_cnt + 1'b1;
`endif
                SHIFT: begin
                    for (int unsigned r = 1; r < ROWS; r++) begin
                        if (RW'(r) <= row_idx) board_q[r] <= board_q[r-1];
                    end
                    board_q[0] <= '0;
                    if (pass_count != 3'd7) pass_count <= pass_count + 3'd1;
                end
                DONE: begin
                    lines_q <= pass_count;
                    total_q <= total_next;
                end
                default: ;
            endcase
        end
    end

    assign board_out     = board_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: directed and random boards against a row-compaction reference model.
module tb_line_clear_engine;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int TW   = 6;
    localparam int BUDGET = 200;

    typedef logic [ROWS-1:0][COLS-1:0] brd_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    brd_t                 board_in;
    brd_t                 board_out;
    logic                 clearing_line;
    logic                 done;
    logic [2:0]           lines_cleared;
    logic [TW-1:0]        total_lines;
    logic [ROWS-1:0]      flash_mask;

    int tests = 0;
    int fails = 0;
    int model_total = 0;

    line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .TOTAL_WIDTH(TW), .FLASH_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .board_in(board_in),
        .board_out(board_out), .clearing_line(clearing_line), .done(done),
        .lines_cleared(lines_cleared), .total_lines(total_lines), .flash_mask(flash_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full rows vanish, surviving rows keep their order and settle at the bottom.
    function automatic void model(input brd_t b, output brd_t o, output int k);
        int w;
        w = ROWS - 1;
        o = '0;
        k = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (&b[r]) k++;
            else begin
                o[w] = b[r];
                w--;
            end
        end
    endfunction

    task automatic run_pass(input string tag, input brd_t b, input bit busy_poke);
        brd_t exp_b;
        int k, kc, cnt;
        model(b, exp_b, k);
        kc = (k > 7) ? 7 : k;
        model_total = model_total + kc;
        if (model_total > (1 << TW) - 1) model_total = (1 << TW) - 1;
        @(negedge clk);
        board_in = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        while (!done && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
            if (busy_poke && cnt == 5) begin
                start = 1'b1;
                board_in = '1;
            end else begin
                start = 1'b0;
                board_in = b;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 256'(cnt), 256'(ROWS + 2 * k + 1));
        check({tag, " busy_at_done"}, 256'(clearing_line), 256'(1));
        check({tag, " flash_mask"}, 256'(flash_mask), 256'(0));
        @(negedge clk);
        check({tag, " done_width"}, 256'(done), 256'(0));
        check({tag, " idle"}, 256'(clearing_line), 256'(0));
        check({tag, " lines"}, 256'(lines_cleared), 256'(kc));
        check({tag, " total"}, 256'(total_lines), 256'(model_total));
        check({tag, " board"}, 256'(board_out), 256'(exp_b));
    endtask

    initial begin
        brd_t b;
        int cnt;
        reset = 1'b1;
        start = 1'b0;
        board_in = '0;
        repeat (2) @(negedge clk);
        check("rst board", 256'(board_out), 256'(0));
        check("rst total", 256'(total_lines), 256'(0));
        check("rst lines", 256'(lines_cleared), 256'(0));
        check("rst busy", 256'(clearing_line), 256'(0));
        check("rst done", 256'(done), 256'(0));
        check("rst flash", 256'(flash_mask), 256'(0));
        reset = 1'b0;

        b = '0;
        run_pass("empty", b, 1'b0);

        b = '0;
        b[19] = '1;
        b[18] = 10'h155;
        run_pass("one", b, 1'b0);

        b = '0;
        b[16] = '1; b[17] = '1; b[18] = '1; b[19] = '1;
        b[12] = 10'h001; b[13] = 10'h002; b[14] = 10'h004; b[15] = 10'h008;
        run_pass("four", b, 1'b0);

        b = '0;
        b[19] = '1; b[17] = '1;
        b[18] = 10'h001;
        b[10] = 10'h2A5;
        run_pass("split", b, 1'b0);

        b = '0;
        b[0] = '1;
        b[1] = 10'h0F0;
        run_pass("top_full", b, 1'b0);

        b = '0;
        b[19] = 10'h3FE;
        b[5] = 10'h011;
        run_pass("busy_ignore", b, 1'b1);
        repeat (3) @(negedge clk);
        check("no_queue", 256'(clearing_line), 256'(0));

        b = '1;
        run_pass("all_full", b, 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 3) == 0) b[r] = '1;
                else b[r] = COLS'($urandom);
            end
            run_pass("random", b, 1'b0);
        end

        b = '1;
        for (int n = 0; n < 10; n++) run_pass("saturate", b, 1'b0);
        check("sat_total", 256'(total_lines), 256'((1 << TW) - 1));

        // abort during the first SHIFT (second cycle after start is accepted)
        b = '0;
        b[19] = '1;
        b[18] = 10'h155;
        @(negedge clk);
        board_in = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        @(negedge clk);
        check("mid busy", 256'(clearing_line), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_total = 0;
        check("abort busy", 256'(clearing_line), 256'(0));
        check("abort board", 256'(board_out), 256'(0));
        check("abort total", 256'(total_lines), 256'(0));
        check("abort lines", 256'(lines_cleared), 256'(0));
        check("abort done", 256'(done), 256'(0));

        b = '0;
        b[19] = '1;
        b[18] = 10'h155;
        run_pass("after_abort", b, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
